// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_8bit_full_subtractor_1bit.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        // Borrow when x=0,y=1, or when x==y and a borrow is already pending
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow register.
module serial_subtractor_8bit
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sh_reg, b_sh_reg, res_sh_reg;
    logic [WIDTH-1:0]   res_sh_next;
    logic [WIDTH-1:0]   diff_reg;
    logic               b_out_reg;
    logic               borrow_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               bit_d, bit_bo;
    logic               accept, last_bit;

    full_subtractor_1bit u_cell (
        .x    (a_sh_reg[0]),
        .y    (b_sh_reg[0]),
        .bin  (borrow_reg),
        .d    (bit_d),
        .bout (bit_bo)
    );

    assign accept      = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign last_bit    = (state_reg == ST_RUN) && (cnt_reg == LAST_CNT);
    assign res_sh_next = {bit_d, res_sh_reg[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registers only
    always_comb begin
        busy  = (state_reg == ST_RUN);
        done  = (state_reg == ST_DONE);
        diff  = diff_reg;
        b_out = b_out_reg;
    end

    // Datapath: operand capture, per-bit shifting and result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            b_out_reg  <= 1'b0;
        end else if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= b_in;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
        end else if (state_reg == ST_RUN) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            res_sh_reg <= res_sh_next;
            borrow_reg <= bit_bo;
            cnt_reg    <= cnt_reg + 1'b1;
            if (last_bit) begin
                diff_reg  <= res_sh_next;
                b_out_reg <= bit_bo;
            end
        end
    end

endmodule : serial_subtractor_8bit

// File: tb/tb_serial_subtractor_8bit.sv
// Directed self-checking bench for serial_subtractor_8bit: handshake timing,
// borrow/wrap cases, back-to-back operation, mid-run reset and a value sweep.
module tb_serial_subtractor_8bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       b_out;

    int total = 0;
    int bad   = 0;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation (accepted at the next edge) and waits for done.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          output logic [7:0] dv, output logic bo, output int lat);
        a = av; b = bv; b_in = bi; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        dv = diff;
        bo = b_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        step();
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || b_out !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b diff=%0d b_out=%b required 0 0 0 0",
                     busy, done, diff, b_out);
        end
        rst = 1'b0; start = 1'b0;
        step();
        $display("reset: busy=%b done=%b diff=%0d b_out=%b", busy, done, diff, b_out);
    endtask

    task automatic test_timing();
        a = 8'd5; b = 8'd3; b_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            total++;
            if (k < 8 && (busy !== 1'b1 || done !== 1'b0)) begin
                bad++;
                $display("FAIL timing_run k=%0d: busy=%b done=%b required 1 0", k, busy, done);
            end else if (k == 8 && (busy !== 1'b0 || done !== 1'b1 || diff !== 8'd2 || b_out !== 1'b0)) begin
                bad++;
                $display("FAIL timing_done: busy=%b done=%b diff=%0d b_out=%b required 0 1 2 0",
                         busy, done, diff, b_out);
            end else if (k == 9 && (done !== 1'b0 || diff !== 8'd2)) begin
                bad++;
                $display("FAIL timing_pulse: done=%b diff=%0d required 0 2", done, diff);
            end
        end
        $display("op 5-3-0: diff=%0d b_out=%b", diff, b_out);
    endtask

    task automatic test_borrow();
        logic [7:0] va [4] = '{8'd0,   8'd0,   8'd200, 8'd7};
        logic [7:0] vb [4] = '{8'd1,   8'd0,   8'd100, 8'd7};
        logic       vi [4] = '{1'b0,   1'b1,   1'b1,   1'b0};
        logic [7:0] ed [4] = '{8'd255, 8'd255, 8'd99,  8'd0};
        logic       eb [4] = '{1'b1,   1'b1,   1'b0,   1'b0};
        logic [7:0] dv;
        logic       bo;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vi[i], dv, bo, lat);
            total++;
            if (lat !== 8 || dv !== ed[i] || bo !== eb[i]) begin
                bad++;
                $display("FAIL borrow %0d-%0d-%0d: lat=%0d diff=%0d b_out=%b required lat=8 diff=%0d b_out=%b",
                         va[i], vb[i], vi[i], lat, dv, bo, ed[i], eb[i]);
            end
            $display("op %0d-%0d-%0d: diff=%0d b_out=%b lat=%0d", va[i], vb[i], vi[i], dv, bo, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        a = 8'd10; b = 8'd4; b_in = 1'b0; start = 1'b1;
        step();
        for (int k = 1; k <= 26; k++) begin
            if (k == 2) begin a = 8'd200; b = 8'd1; end
            if (k == 7) begin a = 8'd10;  b = 8'd4; end
            if (k == 26) start = 1'b0;
            step();
            total++;
            if (k == 8 || k == 17 || k == 26) begin
                if (done !== 1'b1 || diff !== 8'd6 || b_out !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_done k=%0d: done=%b diff=%0d b_out=%b required 1 6 0",
                             k, done, diff, b_out);
                end else begin
                    $display("op 10-4-0 (b2b k=%0d): diff=%0d b_out=%b", k, diff, b_out);
                end
            end else if (done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_nodone k=%0d: done=%b required 0", k, done);
            end
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_ignore_start();
        a = 8'd100; b = 8'd1; b_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 3) begin a = 8'd9; b = 8'd9; b_in = 1'b1; start = 1'b1; end
            if (k == 4) start = 1'b0;
            step();
            total++;
            if (k == 8) begin
                if (done !== 1'b1 || diff !== 8'd99 || b_out !== 1'b0) begin
                    bad++;
                    $display("FAIL ignore_done: done=%b diff=%0d b_out=%b required 1 99 0",
                             done, diff, b_out);
                end
            end else if (done !== 1'b0) begin
                bad++;
                $display("FAIL ignore_nodone k=%0d: done=%b required 0", k, done);
            end
        end
        $display("op 100-1-0 (start mid-run): diff=%0d b_out=%b", diff, b_out);
    endtask

    task automatic test_reset_mid();
        logic [7:0] dv;
        logic       bo;
        int         lat;
        a = 8'd50; b = 8'd20; b_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || b_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%0d b_out=%b required 0 0 0 0",
                     busy, done, diff, b_out);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_quiet k=%0d: done=%b busy=%b required 0 0", k, done, busy);
            end
        end
        run_op(8'd50, 8'd20, 1'b0, dv, bo, lat);
        total++;
        if (lat !== 8 || dv !== 8'd30 || bo !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_restart: lat=%0d diff=%0d b_out=%b required 8 30 0", lat, dv, bo);
        end
        $display("op 50-20-0 (after reset): diff=%0d b_out=%b", dv, bo);
    endtask

    task automatic test_sweep();
        logic [7:0] vals [16] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd15, 8'd16,
                                  8'd31, 8'd64, 8'd100, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
        logic [7:0] dv;
        logic       bo;
        int         lat;
        int         lhs, rhs;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(vals[i], vals[j], c[0], dv, bo, lat);
                    lhs = int'(vals[i]) - int'(vals[j]) - c;
                    rhs = int'(dv) - 256 * int'(bo);
                    total++;
                    if (lat !== 8 || lhs != rhs) begin
                        bad++;
                        $display("FAIL sweep %0d-%0d-%0d: lat=%0d diff=%0d b_out=%b gives %0d required lat=8 value %0d",
                                 vals[i], vals[j], c, lat, dv, bo, rhs, lhs);
                    end
                    $display("sweep %0d-%0d-%0d: diff=%0d b_out=%b", vals[i], vals[j], c, dv, bo);
                end
            end
        end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0; b_in = 1'b0;
        test_reset();
        test_timing();
        step();
        test_borrow();
        test_back_to_back();
        test_ignore_start();
        step();
        test_reset_mid();
        step();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_subtractor_8bit
